// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider and its bench.
package clk_div_pkg;

   // Default widths / reset divisor shared by the divider and its bench
   localparam int CLK_DIV_CNT_W        = 4;
   localparam int CLK_DIV_DEFAULT_HALF = 6;

   // Run-state encoding: the state bit doubles as the running flag
   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUN     = 1'b1
   } run_state_t;

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with rising-edge tick.
// Divisor changes and stop requests only land on the falling edge of clk_out
// (the period boundary), so the output never produces a runt phase.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int CNT_W        = CLK_DIV_CNT_W,
   parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic             running,
   output logic             pending,
   output logic             load_err
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(DEFAULT_HALF);

   run_state_t       state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] half_q;
   logic [CNT_W-1:0] half_pend;

   logic term;
   logic boundary;
   logic load_ok;
   logic load_zero;

   // Terminal count of the current half period; half_q is never 0, so no wrap
   assign term      = (count == (half_q - CNT_ONE));
   // Falling edge of clk_out closes a full period
   assign boundary  = (state == ST_RUN) && term && clk_out;
   assign load_ok   = div_load && (div_in != '0);
   assign load_zero = div_load && (div_in == '0);

   // Run/stop FSM, half-period counter, divisor staging and all registered outputs
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state     <= ST_STOPPED;
         count     <= '0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         running   <= 1'b0;
         pending   <= 1'b0;
         load_err  <= 1'b0;
         half_q    <= HALF_INIT;
         half_pend <= '0;
      end else begin
         // A zero divisor is rejected; staging registers stay untouched
         load_err <= load_zero;
         case (state)
            ST_STOPPED: begin
               clk_out <= 1'b0;
               tick    <= 1'b0;
               count   <= '0;
               // No period in flight, so a staged divisor can land right away
               if (pending) begin
                  half_q  <= half_pend;
                  pending <= 1'b0;
               end
               // A fresh load this cycle is staged after the old one is applied
               if (load_ok) begin
                  half_pend <= div_in;
                  pending   <= 1'b1;
               end
               if (en) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (term) begin
                  count   <= '0;
                  clk_out <= ~clk_out;
                  tick    <= ~clk_out;
               end else begin
                  count <= count + CNT_ONE;
                  tick  <= 1'b0;
               end
               if (boundary) begin
                  // A load landing exactly on the boundary bypasses staging
                  if (load_ok) begin
                     half_q  <= div_in;
                     pending <= 1'b0;
                  end else if (pending) begin
                     half_q  <= half_pend;
                     pending <= 1'b0;
                  end
                  // clk_out toggles to 0 here, so stopping leaves it low
                  if (!en) begin
                     state   <= ST_STOPPED;
                     running <= 1'b0;
                  end
               end else if (load_ok) begin
                  // Last write wins until the next boundary
                  half_pend <= div_in;
                  pending   <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
